// File: rtl/ram_sweep_pkg.sv
// Shared types and helpers for the swept-clear RAM controller.
package ram_sweep_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Even parity over a zero-extended word; callers cast their data to 64 bits.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ram_sweep_ctrl_if.sv
// Access bus between the CPU bus controller (master) and the swept RAM (slave).
// parity_err exists only when RAM_PARITY_EN is defined.
interface ram_sweep_ctrl_if #(
    parameter int unsigned DATA_W = ram_sweep_pkg::DATA_W,
    parameter int unsigned ADDR_W = ram_sweep_pkg::ADDR_W
);
    logic              clear;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              busy;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
`ifdef RAM_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output clear, req, we, addr, wdata,
`ifdef RAM_PARITY_EN
        input  parity_err,
`endif
        input  ready, busy, rdata, rvalid
    );

    modport slave (
        input  clear, req, we, addr, wdata,
`ifdef RAM_PARITY_EN
        output parity_err,
`endif
        output ready, busy, rdata, rvalid
    );

endinterface

// File: rtl/ram_sweep_array.sv
// Storage array: one synchronous write port, one registered read port.
// Contents are never reset; only the read register is.
module ram_sweep_array #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rword
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past DEPTH read back as an all-zero word (data and parity).
    always_ff @(posedge clk) begin
        if (!reset) begin
            rword <= '0;
        end else if (re) begin
            rword <= (32'(raddr) < DEPTH) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/ram_sweep_ctrl.sv
// Single-port RAM with req/ready access, registered read and a one-word-per-cycle
// clear sweep after reset and on demand. RAM_PARITY_EN adds stored parity and parity_err.
module ram_sweep_ctrl #(
    parameter int unsigned       DATA_W    = ram_sweep_pkg::DATA_W,
    parameter int unsigned       ADDR_W    = ram_sweep_pkg::ADDR_W,
    parameter int unsigned       DEPTH     = 16,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    ram_sweep_ctrl_if.slave  bus
);
    import ram_sweep_pkg::*;

`ifdef RAM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
    localparam logic [WORD_W-1:0] CLEAR_WORD = {even_parity(64'(CLEAR_VAL)), CLEAR_VAL};
`else
    localparam int unsigned WORD_W = DATA_W;
    localparam logic [WORD_W-1:0] CLEAR_WORD = CLEAR_VAL;
`endif

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              rvalid_q;
    logic              addr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_re;
    logic [WORD_W-1:0] mem_rword;

    assign addr_ok = (32'(bus.addr) < DEPTH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            rvalid_q <= mem_re;
        end
    end

    // Sweep writes and access writes share the one write port; they never
    // coincide because accesses are only taken in IDLE.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
`ifdef RAM_PARITY_EN
        mem_wdata = {even_parity(64'(bus.wdata)), bus.wdata};
`else
        mem_wdata = bus.wdata;
`endif
        mem_re    = 1'b0;
        if (reset) begin
            case (state)
                ST_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr;
                    mem_wdata = CLEAR_WORD;
                    if (ptr == PTR_LAST) begin
                        ptr_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        ptr_nxt = ptr + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (bus.req) begin
                        if (bus.we) begin
                            mem_we = addr_ok;
                        end else begin
                            mem_re = 1'b1;
                        end
                    end
                    if (bus.clear) begin
                        state_nxt = ST_CLEAR;
                        ptr_nxt   = '0;
                    end
                end
            endcase
        end
    end

    ram_sweep_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (bus.addr),
        .rword (mem_rword)
    );

    assign bus.ready  = (state == ST_IDLE);
    assign bus.busy   = (state == ST_CLEAR);
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = mem_rword[DATA_W-1:0];
`ifdef RAM_PARITY_EN
    assign bus.parity_err = mem_rword[DATA_W] ^ even_parity(64'(mem_rword[DATA_W-1:0]));
`endif

endmodule

// File: doc/ram_sweep_ctrl.md
Name: ram_sweep_ctrl

Overview:
- Parametrised single-port synchronous RAM for the 8-bit microcomputer. It succeeds the fixed 16x8 RAM.
- Adds a req/ready access handshake and a registered read with an rvalid strobe.
- Adds a multi-cycle clear sequencer, one word per cycle, replacing the single-cycle all-word reset. The sequencer runs after reset and on demand.
- Sits between the CPU bus controller and the data store.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- CLEAR_VAL, 0, DATA_W-bit value written by every clear sweep.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  single-cycle request to start a clear sweep.
- req  in  1  access request; accepted on an edge where req=1 and ready=1.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- ready  out  1  1 when the block is in IDLE and can accept an access.
- busy  out  1  1 while a clear sweep is pending or running (state CLEAR).
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle strobe marking new rdata.

Behaviour:
- Reset and clock: reset is synchronous, active-low; clock is clk.
- While reset=0:
  - state=CLEAR, ptr=0.
  - rdata=0, rvalid=0, ready=0, busy=1.
  - Memory contents are not modified.
- FSM states: CLEAR and IDLE.
- ready is derived directly from state: ready = (state==IDLE). busy = (state==CLEAR).
- CLEAR state, per edge with reset=1:
  - mem[ptr] <= CLEAR_VAL.
  - If ptr==DEPTH-1: ptr <= 0 and state <= IDLE.
  - Otherwise ptr <= ptr+1.
- Sweep timing: the first edge after reset rises writes word 0. ready=1 after exactly DEPTH edges.
- Inputs ignored in CLEAR: req and clear. A clear request during CLEAR does not restart the sweep.
- IDLE with clear=1: state <= CLEAR on that edge, ptr=0.
- IDLE with req=1:
  - Write (we=1): mem[addr] <= wdata. rvalid stays 0.
  - Read (we=0): rdata <= mem[addr] and rvalid <= 1. Read latency is 1 edge.
- rvalid is high for exactly one cycle per accepted read. rdata holds its last value otherwise.
- clear and req on the same IDLE edge: both act. The access completes on that edge, then the sweep starts.
  - A read returns the pre-clear data.
  - A write is overwritten by the sweep.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped.
  - Read returns rdata=0 with rvalid=1.
- Reset mid-sweep or mid-access: the sweep restarts from ptr=0 after reset deasserts, and any pending rvalid is cancelled.
- Back-to-back accesses: one per cycle is allowed in IDLE.
- Read-after-write to the same address on the next edge returns the new data.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit: ^wdata on writes, ^CLEAR_VAL on clear.
  - Extra output port parity_err (out, 1), registered alongside rdata.
  - parity_err=1 with rvalid when the stored parity mismatches the stored data.
  - parity_err resets to 0. It reads as 0 for out-of-range reads.
- Undefined: no parity storage, no parity_err port; behaviour otherwise identical.

Decomposition:
- Package ram_sweep_pkg:
  - State enum {ST_CLEAR, ST_IDLE}.
  - Default width constants DATA_W=8 and ADDR_W=4.
  - Parity helper function.
- One natural sub-module: ram_sweep_array, the storage array with a single synchronous write port and a registered read port, no reset on contents.
- The FSM, pointer and handshake stay in the top-level module.

Test Plan:
- Reset release: hold reset=0 for 3 edges, then 1. busy=1 and ready=0 for 16 edges, ready=1 on edge 16; read every address and each returns 0x00.
- Write/read: write 0xA5 to addr 3, then read addr 3. rvalid=1 for one cycle with rdata=0xA5; rdata holds 0xA5 afterwards with rvalid=0.
- Clear during access: in IDLE, assert req read addr 3 (holding 0xA5) together with clear. rdata=0xA5 next cycle, then busy=1 for 16 cycles, and a later read of addr 3 returns 0x00.
- Clear ignored while busy: pulse clear at sweep cycle 5. Sweep still ends after 16 cycles total, and a req issued during the sweep is not executed.
- Out-of-range: with DEPTH=12, ADDR_W=4, write 0x3C to addr 13 then read addr 13. rdata=0x00, rvalid=1, and no in-range word changes.
- RAM_PARITY_EN: force an inverted parity bit on addr 7 via hierarchical access, then read addr 7. parity_err=1 with rvalid=1; a clean read of another address gives parity_err=0.
